// File: rtl/rx_line_buffer_pkg.sv
// lab_pkg: shared state encodings, ASCII constants and the case-fold helper
// used by the rx_line_buffer slice of the lab top level.
//
// State encodings (S_CR / S_LF are reached only when the design is built
// with RX_LINE_BUFFER_CRLF_EN defined).
package lab_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_SEND = 3'd2,
        S_INCR = 3'd3,
        S_CR   = 3'd4,
        S_LF   = 3'd5
    } state_t;

    localparam logic [7:0] ASCII_LC_A     = 8'h61;
    localparam logic [7:0] ASCII_LC_Z     = 8'h7A;
    localparam logic [7:0] ASCII_CASE_OFS = 8'h20;
    localparam logic [7:0] ASCII_CR       = 8'h0D;
    localparam logic [7:0] ASCII_LF       = 8'h0A;

    // Lowercase a..z map to A..Z; every other byte passes through unchanged.
    function automatic logic [7:0] fold_case(input logic [7:0] b);
        if (b >= ASCII_LC_A && b <= ASCII_LC_Z)
            return b - ASCII_CASE_OFS;
        return b;
    endfunction

endpackage

// File: rtl/rx_line_buffer_rise_detect.sv
// rise_detect: one-cycle pulse on the rising edge of a level input.
// The previous level is registered every cycle; the pulse is the current
// level ANDed with the inverted registered level, so it is high in the
// same cycle the input first reads high.
//
// Ports:
//   i_clk      clock, rising edge
//   i_reset_n  synchronous active-low reset, clears the history register
//   i_level    level input to watch
//   o_rise     high for one cycle when i_level goes 0 -> 1
module rise_detect (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_level,
    output logic o_rise
);

    logic r_level_d;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n)
            r_level_d <= 1'b0;
        else
            r_level_d <= i_level;
    end

    assign o_rise = i_level & ~r_level_d;

endmodule

// File: rtl/rx_line_buffer.sv
// rx_line_buffer: collects received UART bytes (lowercase folded to
// uppercase) and, on a rising edge of send_req, replays the stored line to
// the UART transmitter one byte at a time using the transmit /
// is_transmitting handshake. The buffer empties when the line is done.
//
// Build option: RX_LINE_BUFFER_CRLF_EN -- when defined, a CR and an LF are
// transmitted after the last buffered byte, each with its own handshake.
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous active-low reset
//   rx_valid  one-cycle strobe, rx_byte valid
//   rx_byte   received byte
//   send_req  level request; only its rising edge starts a send
//   tx_start  transmit request to the UART (high while waiting for it)
//   tx_byte   byte presented to the UART (0x00 when idle)
//   tx_busy   UART is_transmitting
//   count     number of bytes currently stored
//   sending   high whenever a line is being replayed
//   overflow  sticky: a received byte was dropped
//
// state  | meaning
// S_IDLE | accepting bytes, waiting for a send edge
// S_WAIT | tx_start high, waiting for the UART to go busy
// S_SEND | UART busy with the current byte
// S_INCR | advance read pointer, decide next byte or end of line
// S_CR   | CR handshake (CRLF build only; r_phase 0 = wait, 1 = send)
// S_LF   | LF handshake (CRLF build only; r_phase 0 = wait, 1 = send)
module rx_line_buffer
    import lab_pkg::*;
#(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic              send_req,
    output logic              tx_start,
    output logic [7:0]        tx_byte,
    input  logic              tx_busy,
    output logic [ADDR_W:0]   count,
    output logic              sending,
    output logic              overflow
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_COUNT  = (ADDR_W+1)'(1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_count;
    logic                r_overflow;
    logic [7:0]          r_mem [DEPTH];
`ifdef RX_LINE_BUFFER_CRLF_EN
    logic                r_phase;
`endif

    logic                w_send_rise;
    logic                w_full;
    logic                w_wr_en;
    logic                w_line_done;

    rise_detect u_send_rise (
        .i_clk     (clk),
        .i_reset_n (reset),
        .i_level   (send_req),
        .o_rise    (w_send_rise)
    );

    assign w_full      = (r_count == FULL_COUNT);
    assign w_wr_en     = rx_valid && (r_state == S_IDLE) && !w_full;
    // Compare in count width so a full buffer (rd_ptr 511 -> 512) terminates.
    assign w_line_done = (({1'b0, r_rd_ptr} + ONE_COUNT) == r_count);

    // Memory has no reset; count alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (reset && w_wr_en)
            r_mem[r_wr_ptr] <= fold_case(rx_byte);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
`ifdef RX_LINE_BUFFER_CRLF_EN
            r_phase    <= 1'b0;
`endif
        end else begin
            if (rx_valid && !w_wr_en)
                r_overflow <= 1'b1;

            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_count  <= r_count + ONE_COUNT;
            end

            case (r_state)
                S_IDLE: begin
                    // A same-cycle write counts, so the new byte is sent too.
                    if (w_send_rise && (r_count != '0 || w_wr_en))
                        r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (tx_busy)
                        r_state <= S_SEND;
                end
                S_SEND: begin
                    if (!tx_busy)
                        r_state <= S_INCR;
                end
                S_INCR: begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                    if (w_line_done) begin
`ifdef RX_LINE_BUFFER_CRLF_EN
                        r_state <= S_CR;
                        r_phase <= 1'b0;
`else
                        r_state    <= S_IDLE;
                        r_wr_ptr   <= '0;
                        r_rd_ptr   <= '0;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
`endif
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
`ifdef RX_LINE_BUFFER_CRLF_EN
                S_CR: begin
                    if (!r_phase) begin
                        if (tx_busy)
                            r_phase <= 1'b1;
                    end else if (!tx_busy) begin
                        r_phase <= 1'b0;
                        r_state <= S_LF;
                    end
                end
                S_LF: begin
                    if (!r_phase) begin
                        if (tx_busy)
                            r_phase <= 1'b1;
                    end else if (!tx_busy) begin
                        r_phase    <= 1'b0;
                        r_state    <= S_IDLE;
                        r_wr_ptr   <= '0;
                        r_rd_ptr   <= '0;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        tx_start = (r_state == S_WAIT);
`ifdef RX_LINE_BUFFER_CRLF_EN
        if ((r_state == S_CR || r_state == S_LF) && !r_phase)
            tx_start = 1'b1;
`endif
    end

    always_comb begin
        tx_byte = 8'h00;
        case (r_state)
            S_WAIT, S_SEND, S_INCR: tx_byte = r_mem[r_rd_ptr];
`ifdef RX_LINE_BUFFER_CRLF_EN
            S_CR:                   tx_byte = ASCII_CR;
            S_LF:                   tx_byte = ASCII_LF;
`endif
            default:                tx_byte = 8'h00;
        endcase
    end

    assign count    = r_count;
    assign sending  = (r_state != S_IDLE);
    assign overflow = r_overflow;

endmodule

// File: tb/tb_rx_line_buffer.sv
module tb_rx_line_buffer;

    localparam int DEPTH  = 512;
    localparam int ADDR_W = 9;

    logic              clk;
    logic              reset;
    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic              send_req;
    logic              tx_start;
    logic [7:0]        tx_byte;
    logic              tx_busy;
    logic [ADDR_W:0]   count;
    logic              sending;
    logic              overflow;

    rx_line_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .send_req (send_req),
        .tx_start (tx_start),
        .tx_byte  (tx_byte),
        .tx_busy  (tx_busy),
        .count    (count),
        .sending  (sending),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0] txq[$];
    logic [7:0] expq[$];

    typedef struct {
        logic [7:0] rx;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[10];

    // UART model: sees tx_start, latches the byte, goes busy two cycles
    // after the request and stays busy for 10 cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                txq.push_back(tx_byte);
                @(negedge clk);
                tx_busy = 1'b1;
                repeat (10) @(negedge clk);
                tx_busy = 1'b0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic rx(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Rising edge on send_req; tx_start is expected (or not) one cycle later.
    task automatic send_pulse(input string name, input int exp_start);
        @(negedge clk);
        send_req = 1'b1;
        @(negedge clk);
        check(name, int'(tx_start), exp_start);
        send_req = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (sending && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, int'(sending), 0);
        // let the UART model finish its busy window
        repeat (3) @(negedge clk);
    endtask

    task automatic check_seq(input string name);
        int bad = 0;
`ifdef RX_LINE_BUFFER_CRLF_EN
        expq.push_back(8'h0D);
        expq.push_back(8'h0A);
`endif
        check({name, "_len"}, txq.size(), expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            if (i >= txq.size() || txq[i] !== expq[i]) begin
                if (bad == 0 && i < txq.size())
                    $display("FAIL %s_byte[%0d]: got 0x%0h expected 0x%0h",
                             name, i, txq[i], expq[i]);
                bad++;
            end
        end
        check({name, "_bad_bytes"}, bad, 0);
    endtask

    initial begin
        int n;
        int hits;

        vecs[0] = '{8'h61, 8'h41};
        vecs[1] = '{8'h7A, 8'h5A};
        vecs[2] = '{8'h60, 8'h60};
        vecs[3] = '{8'h7B, 8'h7B};
        vecs[4] = '{8'h00, 8'h00};
        vecs[5] = '{8'h41, 8'h41};
        vecs[6] = '{8'h6D, 8'h4D};
        vecs[7] = '{8'hFF, 8'hFF};
        vecs[8] = '{8'hE1, 8'hE1};
        vecs[9] = '{8'h30, 8'h30};

        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        send_req = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_count",    int'(count),    0);
        check("rst_sending",  int'(sending),  0);
        check("rst_tx_start", int'(tx_start), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_tx_byte",  int'(tx_byte),  0);

        // reset while filled
        rx(8'h31); rx(8'h32); rx(8'h33);
        @(negedge clk);
        check("fill3_count", int'(count), 3);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("rstfill_count",    int'(count),    0);
        check("rstfill_overflow", int'(overflow), 0);
        check("rstfill_tx_start", int'(tx_start), 0);

        // single-byte fold table
        for (int v = 0; v < 10; v++) begin
            txq.delete();
            expq.delete();
            rx(vecs[v].rx);
            send_pulse($sformatf("vec%0d_start", v), 1);
            wait_idle($sformatf("vec%0d", v), 200);
            expq.push_back(vecs[v].exp);
            check_seq($sformatf("vec%0d", v));
        end

        // "aB{z"
        txq.delete();
        expq.delete();
        rx(8'h61); rx(8'h42); rx(8'h7B); rx(8'h7A);
        @(negedge clk);
        check("fold_count", int'(count), 4);
        send_pulse("fold_start", 1);
        wait_idle("fold", 500);
        expq = '{8'h41, 8'h42, 8'h7B, 8'h5A};
        check_seq("fold");
        check("fold_count_after", int'(count), 0);

        // empty send
        txq.delete();
        send_pulse("empty_start", 0);
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_start || sending) hits++;
        end
        check("empty_activity", hits, 0);
        check("empty_txq", txq.size(), 0);

        // fill and overflow
        txq.delete();
        expq.delete();
        for (int i = 0; i < DEPTH + 2; i++)
            rx(8'h30 + 8'(i % 10));
        @(negedge clk);
        check("full_count",    int'(count),    512);
        check("full_overflow", int'(overflow), 1);
        send_pulse("full_start", 1);
        wait_idle("full", 10000);
        for (int i = 0; i < DEPTH; i++)
            expq.push_back(8'h30 + 8'(i % 10));
        check_seq("full");
        check("full_overflow_after", int'(overflow), 0);
        check("full_count_after",    int'(count),    0);

        // receive during send
        txq.delete();
        expq.delete();
        rx(8'h58); rx(8'h59);
        send_pulse("rxsend_start", 1);
        n = 0;
        while (!tx_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rxsend_busy_seen", int'(tx_busy), 1);
        rx(8'h7A);
        check("rxsend_overflow", int'(overflow), 1);
        check("rxsend_count",    int'(count),    2);
        wait_idle("rxsend", 500);
        expq = '{8'h58, 8'h59};
        check_seq("rxsend");
        check("rxsend_overflow_after", int'(overflow), 0);

        // same-cycle write and send rise, then hold send_req high
        txq.delete();
        expq.delete();
        rx(8'h41);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = 8'h62;
        send_req = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check("same_start", int'(tx_start), 1);
        wait_idle("same", 500);
        expq = '{8'h41, 8'h42};
        check_seq("same");
        txq.delete();
        hits = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (sending || tx_start) hits++;
        end
        check("hold_no_retrigger", hits, 0);
        check("hold_txq", txq.size(), 0);
        send_req = 1'b0;

        // "HI" (gains CR LF in the CRLF build)
        txq.delete();
        expq.delete();
        rx(8'h48); rx(8'h69);
        send_pulse("hi_start", 1);
        wait_idle("hi", 500);
        expq = '{8'h48, 8'h49};
        check_seq("hi");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rx_line_buffer.md
Name: rx_line_buffer

Overview:
- Buffers bytes from the UART receiver into an internal memory, folding lowercase ASCII to uppercase.
- On a send request, replays the buffered line to the UART transmitter using the transmit / is_transmitting handshake, then empties itself.
- Sits between the uart block's receive outputs and its transmit inputs in the lab top level.
- Takes the debounced button as the send request.

Parameters:
- DEPTH, 512, number of byte entries in the buffer (power of two).
- ADDR_W, 9, log2(DEPTH); the count is ADDR_W+1 bits wide.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset; reset==0 at a clk edge resets the block.
- rx_valid  in  1  one-cycle pulse; rx_byte is valid (uart "received").
- rx_byte  in  8  received byte.
- send_req  in  1  debounced level request; only its rising edge is acted on.
- tx_start  out  1  transmit request to uart ("transmit").
- tx_byte  out  8  byte to transmit.
- tx_busy  in  1  uart "is_transmitting".
- count  out  ADDR_W+1  number of bytes currently stored.
- sending  out  1  high whenever the FSM is not in S_IDLE.
- overflow  out  1  sticky flag: a received byte was dropped.

Behaviour:
- Reset (reset==0): state S_IDLE, wr_ptr=0, rd_ptr=0, count=0, overflow=0, tx_start=0, sending=0, edge register=0. Memory contents are not cleared; count defines validity.
- Reset wins over every other event, including mid-send and a same-cycle rx_valid.
- Case fold: if 0x61<=rx_byte<=0x7A, store rx_byte-0x20; otherwise store rx_byte unchanged. This applies to all values, including 0x00.
- Write: on rx_valid in S_IDLE with count<DEPTH, mem[wr_ptr]<=folded byte, wr_ptr++, count++. The byte is visible in count on the next cycle.
- Dropped writes:
  - rx_valid while count==DEPTH sets overflow.
  - rx_valid in any state other than S_IDLE sets overflow.
  - In both cases the byte is discarded.
- Edge detect: send_rise = send_req & ~send_req_d, where send_req_d is registered every cycle.
- FSM states: S_IDLE, S_WAIT, S_SEND, S_INCR (plus S_CR and S_LF with the optional feature).
  - S_IDLE -> S_WAIT when send_rise and count>0. send_rise with count==0 is ignored.
  - If rx_valid and send_rise occur in the same S_IDLE cycle, the write completes first; the new byte is included in the send.
  - S_WAIT: tx_start=1. Move to S_SEND on tx_busy==1.
  - S_SEND: tx_start=0. Move to S_INCR on tx_busy==0.
  - S_INCR: rd_ptr++. If rd_ptr+1==count, the line is done: go to S_IDLE and clear wr_ptr, rd_ptr, count and overflow. Otherwise go to S_WAIT.
- tx_start is a combinational decode of state==S_WAIT.
- tx_byte = mem[rd_ptr] (combinational read) in S_WAIT/S_SEND/S_INCR; 0x00 in S_IDLE.
- Latency: the send_rise cycle N gives S_WAIT and tx_start=1 at N+1.
- Holding send_req high after a send does not retrigger; a fresh rising edge is required.
- Pointer wrap: pointers are ADDR_W bits; a full buffer (count==DEPTH) sends all DEPTH bytes. The pointer wrap to 0 is harmless because pointers clear at the end of the send.

Optional Feature:
- Macro: RX_LINE_BUFFER_CRLF_EN.
- Defined: after the last buffered byte, S_INCR goes to S_CR instead of S_IDLE.
  - S_CR and S_LF each repeat the WAIT/SEND handshake with tx_byte=0x0D and then 0x0A.
  - The buffer clears on leaving S_LF.
- Undefined: S_CR and S_LF do not exist; the line ends with its last data byte.

Decomposition:
- Shared package lab_pkg:
  - state typedef/encodings (S_IDLE..S_LF);
  - ASCII constants ASCII_LC_A=0x61, ASCII_LC_Z=0x7A, ASCII_CASE_OFS=0x20, ASCII_CR=0x0D, ASCII_LF=0x0A.
- One natural sub-module: rise_detect (registered rising-edge pulse), reused for send_req.

Test Plan:
- Reset while filled: load 3 bytes, drive reset=0 for 1 cycle -> count=0, overflow=0, tx_start=0 next cycle.
- Case fold: receive "aB{z" (0x61,0x42,0x7B,0x7A), then pulse send_req; uart model asserts tx_busy 2 cycles after tx_start, holds it 10 cycles -> tx_byte sequence 0x41,0x42,0x7B,0x5A, then count=0 and sending=0.
- Empty send: send_req rising with count==0 -> no tx_start ever; state stays S_IDLE.
- Fill and overflow: DEPTH+2 rx_valid pulses -> count=512, overflow=1. Sending then transmits exactly 512 bytes and clears overflow.
- Receive during send: rx_valid while sending=1 -> byte not stored, overflow=1, and the current transmission sequence is unaltered.
- Same-cycle write and send_rise, plus level hold: both events on one cycle with count==1 -> 2 bytes sent. Holding send_req high afterwards gives no second send.
- With RX_LINE_BUFFER_CRLF_EN defined: send "HI" -> tx sequence 0x48,0x49,0x0D,0x0A.
